// File: rtl/ariane_pkg.sv
// Shared MMU types: PTW refill record and the miss-arbiter FSM encoding.
package ariane_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_2m;
        logic        is_1g;
        logic [26:0] vpn;
        logic [15:0] asid;
        logic [63:0] content;
    } tlb_update_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrain
    } tlb_miss_arb_state_e;

endpackage

// File: rtl/riscv_pkg.sv
// Architectural constants shared by the MMU blocks.
package riscv;

    localparam int unsigned VLEN = 39;

endpackage

// File: rtl/tlb_miss_arb.sv
// Arbitrates ITLB/DTLB misses onto one shared page-table walker and routes the refill back.
// Optional walk counters are built when TLB_MISS_ARB_PERF_EN is defined.
module tlb_miss_arb
    import ariane_pkg::*;
#(
    parameter int unsigned ASID_WIDTH = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   itlb_miss_i,
    input  logic                   dtlb_miss_i,
    input  logic [riscv::VLEN-1:0] itlb_vaddr_i,
    input  logic [riscv::VLEN-1:0] dtlb_vaddr_i,
    input  logic [ASID_WIDTH-1:0]  itlb_asid_i,
    input  logic [ASID_WIDTH-1:0]  dtlb_asid_i,
    input  logic                   dtlb_is_store_i,
    output logic                   ptw_req_o,
    output logic [riscv::VLEN-1:0] ptw_vaddr_o,
    output logic [ASID_WIDTH-1:0]  ptw_asid_o,
    output logic                   ptw_is_store_o,
    output logic                   ptw_is_itlb_o,
    input  logic                   ptw_gnt_i,
    input  logic                   ptw_done_i,
    input  logic                   ptw_error_i,
    input  tlb_update_t            ptw_update_i,
    output tlb_update_t            itlb_update_o,
    output tlb_update_t            dtlb_update_o,
    output logic                   itlb_err_o,
    output logic                   dtlb_err_o
`ifdef TLB_MISS_ARB_PERF_EN
    ,
    output logic [31:0]            itlb_walks_o,
    output logic [31:0]            dtlb_walks_o,
    output logic [31:0]            flushed_walks_o
`endif
);

    tlb_miss_arb_state_e    state_q, state_d;
    logic                   last_itlb_q, last_itlb_d;
    logic [riscv::VLEN-1:0] vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0]  asid_q, asid_d;
    logic                   is_store_q, is_store_d;
    logic                   is_itlb_q, is_itlb_d;
    logic                   pick_itlb;

    // Tie goes to whichever side was not served last.
    assign pick_itlb = itlb_miss_i & (~dtlb_miss_i | ~last_itlb_q);

    always_comb begin
        state_d       = state_q;
        last_itlb_d   = last_itlb_q;
        vaddr_d       = vaddr_q;
        asid_d        = asid_q;
        is_store_d    = is_store_q;
        is_itlb_d     = is_itlb_q;
        itlb_update_o = '0;
        dtlb_update_o = '0;
        itlb_err_o    = 1'b0;
        dtlb_err_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!flush_i && (itlb_miss_i || dtlb_miss_i)) begin
                    is_itlb_d  = pick_itlb;
                    vaddr_d    = pick_itlb ? itlb_vaddr_i : dtlb_vaddr_i;
                    asid_d     = pick_itlb ? itlb_asid_i : dtlb_asid_i;
                    is_store_d = ~pick_itlb & dtlb_is_store_i;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (ptw_gnt_i) begin
                    state_d = flush_i ? StDrain : StWait;
                end else if (flush_i) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (ptw_done_i) begin
                    state_d = StIdle;
                    if (!flush_i) begin
                        last_itlb_d = is_itlb_q;
                        if (ptw_error_i) begin
                            itlb_err_o = is_itlb_q;
                            dtlb_err_o = ~is_itlb_q;
                        end else if (is_itlb_q) begin
                            itlb_update_o = ptw_update_i;
                        end else begin
                            dtlb_update_o = ptw_update_i;
                        end
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (ptw_done_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            last_itlb_q <= 1'b1;
            vaddr_q     <= '0;
            asid_q      <= '0;
            is_store_q  <= 1'b0;
            is_itlb_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_itlb_q <= last_itlb_d;
            vaddr_q     <= vaddr_d;
            asid_q      <= asid_d;
            is_store_q  <= is_store_d;
            is_itlb_q   <= is_itlb_d;
        end
    end

    assign ptw_req_o      = (state_q == StReq);
    assign ptw_vaddr_o    = vaddr_q;
    assign ptw_asid_o     = asid_q;
    assign ptw_is_store_o = is_store_q;
    assign ptw_is_itlb_o  = is_itlb_q;

`ifdef TLB_MISS_ARB_PERF_EN
    logic [31:0] itlb_walks_q, dtlb_walks_q, flushed_walks_q;
    logic        gnt_acc, drain_entry;

    assign gnt_acc     = (state_q == StReq) & ptw_gnt_i;
    assign drain_entry = (gnt_acc & flush_i) | ((state_q == StWait) & flush_i & ~ptw_done_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            itlb_walks_q    <= '0;
            dtlb_walks_q    <= '0;
            flushed_walks_q <= '0;
        end else begin
            if (gnt_acc && is_itlb_q) begin
                itlb_walks_q <= itlb_walks_q + 32'd1;
            end
            if (gnt_acc && !is_itlb_q) begin
                dtlb_walks_q <= dtlb_walks_q + 32'd1;
            end
            if (drain_entry) begin
                flushed_walks_q <= flushed_walks_q + 32'd1;
            end
        end
    end

    assign itlb_walks_o    = itlb_walks_q;
    assign dtlb_walks_o    = dtlb_walks_q;
    assign flushed_walks_o = flushed_walks_q;
`endif

endmodule
